// File: rtl/spi_temp_pkg.sv
// Shared types and defaults for the multi-sensor SPI temperature scanner.
package spi_temp_pkg;

    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_TEMP_SHIFT = 7;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        DONE,
        GAP
    } state_t;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_phase.sv
// Half-period timer: while run is high, phase_done ticks once every CLK_DIV
// cycles and the count restarts, so each timed FSM state lasts exactly CLK_DIV.
module spi_clk_phase #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic phase_done
);

    localparam int CW = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign phase_done = run && (cnt == CW'(CLK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !run || phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_temp_scanner.sv
// SPI master reading N_CH LM70-style sensors on a shared SCK/SIO bus, with
// single-shot or round-robin scanning, threshold alerts and a valid/ready result port.
module spi_temp_scanner
    import spi_temp_pkg::*;
#(
    parameter  int N_CH       = 2,
    parameter  int FRAME_BITS = DEF_FRAME_BITS,
    parameter  int TEMP_SHIFT = DEF_TEMP_SHIFT,
    parameter  int CLK_DIV    = 2,
    parameter  int GAP_CYC    = 4,
    localparam int CHW        = width_of(N_CH),
    localparam int TW         = FRAME_BITS - TEMP_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CHW-1:0]        ch_sel,
    input  logic                  scan_en,
    input  logic [TW-1:0]         t_high,
    input  logic                  sio,
    output logic                  sck,
    output logic [N_CH-1:0]       cs_n,
    output logic                  busy,
    output logic [FRAME_BITS-1:0] frame,
    output logic [TW-1:0]         temp_c,
    output logic [CHW-1:0]        data_ch,
    output logic                  valid,
    input  logic                  ready,
    output logic [N_CH-1:0]       alert,
    output logic                  err
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam int GCW = width_of(GAP_CYC);
    localparam logic [CHW:0] N_CH_W = (CHW + 1)'(N_CH);

    state_t                state_q, state_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic                  scan_frame_q, scan_frame_d;
    logic [CHW-1:0]        scan_ptr;
    logic [FRAME_BITS-1:0] shreg;
    logic [BCW-1:0]        bit_cnt;
    logic [GCW-1:0]        gap_cnt;
    logic                  gap_done;
    logic                  in_frame;
    logic                  phase_done;
    logic                  bad_req;
    logic                  cs_next;

    assign in_frame = state_q inside {SETUP, SCK_HI, SCK_LO, HOLD};
    assign cs_next  = state_d inside {SETUP, SCK_HI, SCK_LO, HOLD};
    assign gap_done = (gap_cnt == GCW'(GAP_CYC - 1));
    assign busy     = (state_q != IDLE);
    assign valid    = (state_q == DONE);

    spi_clk_phase #(
        .CLK_DIV(CLK_DIV)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .run       (in_frame),
        .phase_done(phase_done)
    );

    // NOTE: every signal written here gets a default first, otherwise an untaken branch infers a latch.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        scan_frame_d = scan_frame_q;
        bad_req      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    state_d      = SETUP;
                    ch_d         = scan_ptr;
                    scan_frame_d = 1'b1;
                end else if (start) begin
                    if ({1'b0, ch_sel} < N_CH_W) begin
                        state_d      = SETUP;
                        ch_d         = ch_sel;
                        scan_frame_d = 1'b0;
                    end else begin
                        bad_req = 1'b1;
                    end
                end
            end
            SETUP:   if (phase_done) state_d = SCK_HI;
            SCK_HI:  if (phase_done) state_d = SCK_LO;
            SCK_LO:  if (phase_done) state_d = (bit_cnt == BCW'(FRAME_BITS)) ? HOLD : SCK_HI;
            HOLD:    if (phase_done) state_d = DONE;
            DONE:    if (ready) state_d = GAP;
            GAP:     if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            scan_frame_q <= 1'b0;
            scan_ptr     <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            sck          <= 1'b0;
            cs_n         <= '1;
            frame        <= '0;
            temp_c       <= '0;
            data_ch      <= '0;
            alert        <= '0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            scan_frame_q <= scan_frame_d;
            err          <= bad_req;
            // Bus pins are registered from the next state so they are glitch-free and align with it.
            sck          <= (state_d == SCK_HI);
            cs_n         <= cs_next ? ~(N_CH'(1) << ch_d) : '1;

            if (state_q == IDLE) begin
                bit_cnt <= '0;
            end else if (state_q == SCK_HI && phase_done) begin
                shreg   <= {shreg[FRAME_BITS-2:0], sio};
                bit_cnt <= bit_cnt + BCW'(1);
            end

            if (state_q == HOLD && phase_done) begin
                frame        <= shreg;
                temp_c       <= shreg[FRAME_BITS-1:TEMP_SHIFT];
                data_ch      <= ch_q;
                alert[ch_q]  <= $signed(shreg[FRAME_BITS-1:TEMP_SHIFT]) > $signed(t_high);
            end

            gap_cnt <= (state_q == GAP && !gap_done) ? gap_cnt + GCW'(1) : '0;

            if (state_q == GAP && gap_done && scan_frame_q) begin
                scan_ptr <= (scan_ptr == CHW'(N_CH - 1)) ? '0 : scan_ptr + CHW'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_temp_scanner.sv
// Self-checking bench for spi_temp_scanner: behavioural LM70-style sensors,
// a table of single-shot reads, and directed scan/backpressure/reset/error sequences.
module tb_spi_temp_scanner;

    localparam int N_CH    = 2;
    localparam int FB      = 16;
    localparam int TS      = 7;
    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 4;
    localparam int CHW     = 1;
    localparam int TW      = FB - TS;
    localparam int CS_LOW  = (2 + 2 * FB) * CLK_DIV;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [CHW-1:0]  ch_sel;
    logic            scan_en;
    logic [TW-1:0]   t_high;
    logic            sio;
    logic            sck;
    logic [N_CH-1:0] cs_n;
    logic            busy;
    logic [FB-1:0]   frame;
    logic [TW-1:0]   temp_c;
    logic [CHW-1:0]  data_ch;
    logic            valid;
    logic            ready;
    logic [N_CH-1:0] alert;
    logic            err;

    // Three-channel instance: a 2-bit ch_sel can name a channel that does not exist.
    logic            start3;
    logic [1:0]      ch_sel3;
    logic            sck3;
    logic [2:0]      cs_n3;
    logic            busy3;
    logic [FB-1:0]   frame3;
    logic [TW-1:0]   temp_c3;
    logic [1:0]      data_ch3;
    logic            valid3;
    logic [2:0]      alert3;
    logic            err3;

    always #5 clk = ~clk;

    spi_temp_scanner #(
        .N_CH(N_CH), .FRAME_BITS(FB), .TEMP_SHIFT(TS), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .scan_en(scan_en),
        .t_high(t_high), .sio(sio), .sck(sck), .cs_n(cs_n), .busy(busy), .frame(frame),
        .temp_c(temp_c), .data_ch(data_ch), .valid(valid), .ready(ready), .alert(alert),
        .err(err)
    );

    spi_temp_scanner #(
        .N_CH(3), .FRAME_BITS(FB), .TEMP_SHIFT(TS), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
    ) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .ch_sel(ch_sel3), .scan_en(1'b0),
        .t_high(9'd0), .sio(1'b0), .sck(sck3), .cs_n(cs_n3), .busy(busy3), .frame(frame3),
        .temp_c(temp_c3), .data_ch(data_ch3), .valid(valid3), .ready(1'b1), .alert(alert3),
        .err(err3)
    );

    // Sensors: frame loaded on CS fall, MSB driven on SIO, shifted on SCK fall.
    logic [FB-1:0]   preset [N_CH];
    logic [N_CH-1:0] sio_bits;

    for (genvar g = 0; g < N_CH; g++) begin : g_sensor
        logic [FB-1:0] sr = '0;
        logic          cs_prev = 1'b1;
        always @(cs_n[g] or negedge sck) begin
            if (cs_n[g] !== cs_prev) begin
                if (cs_n[g] === 1'b0) sr = preset[g];
                cs_prev = cs_n[g];
            end else if (cs_n[g] === 1'b0) begin
                sr = {sr[FB-2:0], 1'b0};
            end
        end
        assign sio_bits[g] = (cs_n[g] === 1'b0) && sr[FB-1];
    end

    assign sio = |sio_bits;

    // Bus monitor, sampled on the falling clk edge.
    int   cs_low_len  = 0;
    int   sck_cnt     = 0;
    int   last_low    = 0;
    int   last_sck    = 0;
    int   gap_len     = 0;
    int   last_gap    = 0;
    int   frames_seen = 0;
    int   onehot_bad  = 0;
    int   err_cnt     = 0;
    int   valid_rises = 0;
    logic cs_was_low  = 1'b0;
    logic sck_prev    = 1'b0;
    logic valid_prev  = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            cs_low_len = 0;
            sck_cnt    = 0;
            gap_len    = 0;
            cs_was_low = 1'b0;
        end else if (cs_n !== '1) begin
            if (!cs_was_low) last_gap = gap_len;
            cs_low_len++;
            if (sck && !sck_prev) sck_cnt++;
            cs_was_low = 1'b1;
        end else begin
            if (cs_was_low) begin
                last_low   = cs_low_len;
                last_sck   = sck_cnt;
                frames_seen++;
                cs_low_len = 0;
                sck_cnt    = 0;
                gap_len    = 0;
            end
            gap_len++;
            cs_was_low = 1'b0;
        end
        if ($countones(~cs_n) > 1) onehot_bad++;
        if (err === 1'b1) err_cnt++;
        if (valid && !valid_prev) valid_rises++;
        sck_prev   = sck;
        valid_prev = valid;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic single_shot(input logic [CHW-1:0] ch);
        start  = 1'b1;
        ch_sel = ch;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_valid(input string what, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check($sformatf("%s valid seen", what), 32'(ok), 1);
    endtask

    task automatic wait_idle(input string what);
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check($sformatf("%s returns idle", what), 32'(ok), 1);
    endtask

    typedef struct {
        logic [CHW-1:0] ch;
        logic [FB-1:0]  preset;
        logic [TW-1:0]  t_high;
        logic [TW-1:0]  exp_temp;
        logic           exp_alert;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit              ok;
        logic [N_CH-1:0] exp_alert;
        int              f0, e0, v0, bad;

        vecs[0] = '{1'b0, 16'h041F, 9'h014, 9'h008, 1'b0};  //   8 > 20
        vecs[1] = '{1'b1, 16'hFC1F, 9'h1F7, 9'h1F8, 1'b1};  //  -8 > -9
        vecs[2] = '{1'b0, 16'h0B9F, 9'h017, 9'h017, 1'b0};  //  23 > 23 (equal, no alert)
        vecs[3] = '{1'b0, 16'h0B9F, 9'h016, 9'h017, 1'b1};  //  23 > 22
        vecs[4] = '{1'b1, 16'h8000, 9'h100, 9'h100, 1'b0};  // -256 > -256
        vecs[5] = '{1'b1, 16'h7FFF, 9'h0FE, 9'h0FF, 1'b1};  // 255 > 254
        vecs[6] = '{1'b1, 16'hFFFF, 9'h1FF, 9'h1FF, 1'b0};  // -1/128 floors to -1

        rst     = 1'b1;
        start   = 1'b0;
        ch_sel  = '0;
        scan_en = 1'b0;
        t_high  = '0;
        ready   = 1'b1;
        start3  = 1'b0;
        ch_sel3 = '0;
        preset[0] = '0;
        preset[1] = '0;
        tick(3);

        check("reset sck", 32'(sck), 0);
        check("reset cs_n", 32'(cs_n), 32'h3);
        check("reset busy", 32'(busy), 0);
        check("reset valid", 32'(valid), 0);
        check("reset frame", 32'(frame), 0);
        check("reset temp_c", 32'(temp_c), 0);
        check("reset data_ch", 32'(data_ch), 0);
        check("reset alert", 32'(alert), 0);
        check("reset err", 32'(err), 0);
        rst = 1'b0;
        tick(2);

        // Single-shot table.
        exp_alert = '0;
        for (int i = 0; i < 7; i++) begin
            preset[vecs[i].ch] = vecs[i].preset;
            t_high             = vecs[i].t_high;
            single_shot(vecs[i].ch);
            wait_valid($sformatf("vec%0d", i), ok);
            exp_alert[vecs[i].ch] = vecs[i].exp_alert;
            if (ok) begin
                check($sformatf("vec%0d frame", i), 32'(frame), 32'(vecs[i].preset));
                check($sformatf("vec%0d temp_c", i), 32'(temp_c), 32'(vecs[i].exp_temp));
                check($sformatf("vec%0d data_ch", i), 32'(data_ch), 32'(vecs[i].ch));
                check($sformatf("vec%0d alert", i), 32'(alert), 32'(exp_alert));
                check($sformatf("vec%0d cs low cycles", i), 32'(last_low), CS_LOW);
                check($sformatf("vec%0d sck pulses", i), 32'(last_sck), FB);
                check($sformatf("vec%0d busy", i), 32'(busy), 1);
                tick(1);
                check($sformatf("vec%0d valid one cycle", i), 32'(valid), 0);
            end
            wait_idle($sformatf("vec%0d", i));
        end

        // Threshold change must not touch stored alerts.
        t_high = 9'h100;
        tick(5);
        check("alert held after t_high change", 32'(alert), 32'(exp_alert));

        // Round-robin scan with wrap.
        do_reset();
        preset[0] = 16'h0B9F;
        preset[1] = 16'hFC1F;
        t_high    = 9'd20;
        f0        = frames_seen;
        scan_en   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid($sformatf("scan%0d", k), ok);
            if (ok) begin
                check($sformatf("scan%0d data_ch", k), 32'(data_ch), 32'(k % 2));
                check($sformatf("scan%0d temp_c", k), 32'(temp_c), (k % 2) ? 32'h1F8 : 32'h017);
                check($sformatf("scan%0d alert", k), 32'(alert), 32'h1);
                if (k > 0) check($sformatf("scan%0d cs gap >= GAP_CYC", k), 32'(last_gap >= GAP_CYC), 1);
            end
            if (k == 2) scan_en = 1'b0;
            tick(1);
        end
        wait_idle("scan stop");
        tick(50);
        check("scan stops after frame", 32'(frames_seen - f0), 3);
        check("scan stopped idle", 32'(busy), 0);

        // Backpressure: result held, no bus activity until accepted.
        do_reset();
        ready   = 1'b0;
        scan_en = 1'b1;
        wait_valid("bp first", ok);
        f0  = frames_seen;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (!valid || frame !== 16'h0B9F || data_ch !== 1'b0 || cs_n !== '1) bad++;
            tick(1);
        end
        check("bp result held", 32'(bad), 0);
        check("bp no new frame", 32'(frames_seen - f0), 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("bp valid drops after accept", 32'(valid), 0);
        wait_valid("bp second", ok);
        check("bp second data_ch", 32'(data_ch), 1);
        check("bp second frame", 32'(frame), 32'hFC1F);
        tick(100);
        check("bp exactly one frame", 32'(frames_seen - f0), 1);
        scan_en = 1'b0;
        ready   = 1'b1;
        tick(1);
        wait_idle("bp drain");

        // Reset in the middle of a frame.
        do_reset();
        preset[0] = 16'h041F;
        single_shot(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (sck_cnt >= 5 && !sck) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("rst: fifth sck pulse seen", 32'(ok), 1);
        v0  = valid_rises;
        rst = 1'b1;
        tick(1);
        check("rst mid cs_n", 32'(cs_n), 32'h3);
        check("rst mid sck", 32'(sck), 0);
        check("rst mid valid", 32'(valid), 0);
        rst = 1'b0;
        tick(100);
        check("rst mid no result", 32'(valid_rises - v0), 0);
        single_shot(1'b0);
        wait_valid("post-reset shot", ok);
        check("post-reset frame", 32'(frame), 32'h041F);
        check("post-reset cs low cycles", 32'(last_low), CS_LOW);
        wait_idle("post-reset");

        // Out-of-range channel on the three-channel instance.
        start3  = 1'b1;
        ch_sel3 = 2'd3;
        tick(1);
        start3  = 1'b0;
        check("bad ch err pulse", 32'(err3), 1);
        check("bad ch busy", 32'(busy3), 0);
        check("bad ch cs_n", 32'(cs_n3), 32'h7);
        tick(1);
        check("bad ch err clears", 32'(err3), 0);
        check("bad ch still idle", 32'(busy3), 0);
        start3  = 1'b1;
        ch_sel3 = 2'd2;
        tick(1);
        start3  = 1'b0;
        check("last ch accepted no err", 32'(err3), 0);
        check("last ch cs_n", 32'(cs_n3), 32'h3);

        // start while busy is ignored.
        do_reset();
        preset[1] = 16'hFC1F;
        e0 = err_cnt;
        v0 = valid_rises;
        f0 = frames_seen;
        single_shot(1'b1);
        tick(10);
        single_shot(1'b0);
        tick(10);
        single_shot(1'b1);
        wait_valid("busy start", ok);
        check("busy start data_ch", 32'(data_ch), 1);
        check("busy start frame", 32'(frame), 32'hFC1F);
        tick(150);
        check("busy start one frame", 32'(frames_seen - f0), 1);
        check("busy start one result", 32'(valid_rises - v0), 1);
        check("busy start no err", 32'(err_cnt - e0), 0);
        check("busy start idle", 32'(busy), 0);

        check("only one cs_n low", 32'(onehot_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
